// File: rtl/rr_grant_indexer.sv
// Eight-way round-robin arbiter emitting a registered 3-bit grant index plus valid.
// Grants hold until done, request drop, or the hold limit; one dead cycle between grants.
module rr_grant_indexer #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       g2,
  output logic       g1,
  output logic       g0,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [0:0] dbg_state,
  output logic [2:0] dbg_ptr
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] state;
  logic [2:0] ptr;
  logic [2:0] idx;
  logic [7:0] hcnt;
  logic [2:0] pick;
  logic       rel_done;
  logic       rel_drop;
  logic       rel_hold;

  // Scan downward in offset so the set bit closest to ptr is the one left in pick.
  always_comb begin
    pick = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr + 3'(i)]) pick = ptr + 3'(i);
    end
  end

  assign rel_done = done;
  assign rel_drop = !req[idx];
  assign rel_hold = (hcnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      idx     <= 3'd0;
      hcnt    <= 8'd0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 8'd0) begin
            idx   <= pick;
            hcnt  <= 8'd0;
            state <= GRANT;
          end
        end
        default: begin
          if (rel_done || rel_drop || rel_hold) begin
            state   <= IDLE;
            ptr     <= idx + 3'd1;
            timeout <= rel_hold && !rel_done && !rel_drop;
          end else if (hcnt != 8'hFF) begin
            hcnt <= hcnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign {g2, g1, g0} = idx;
  assign gnt_valid    = (state == GRANT);
  assign dbg_state    = state;
  assign dbg_ptr      = ptr;

endmodule

// File: tb/tb_rr_grant_indexer.sv
// Directed bench for rr_grant_indexer with MAX_HOLD=4: reset, fairness, wrap,
// hold timeout, simultaneous release causes, request drop and reset mid-grant.
module tb_rr_grant_indexer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       g2, g1, g0;
  logic       gnt_valid;
  logic       timeout;
  logic [0:0] dbg_state;
  logic [2:0] dbg_ptr;

  int checks = 0;
  int failures = 0;

  rr_grant_indexer #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .g2(g2), .g1(g1), .g0(g0),
    .gnt_valid(gnt_valid), .timeout(timeout),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks valid, index and timeout together at one sample point.
  task automatic chk_out(input string tag, input logic v, input logic [2:0] ix, input logic t);
    chk({tag, "_valid"}, {7'd0, gnt_valid}, {7'd0, v});
    if (v) chk({tag, "_idx"}, {5'd0, g2, g1, g0}, {5'd0, ix});
    chk({tag, "_timeout"}, {7'd0, timeout}, {7'd0, t});
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; done = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 3'd0, 1'b0);
    chk("reset_idx", {5'd0, g2, g1, g0}, 8'd0);
    chk("reset_ptr", {5'd0, dbg_ptr}, 8'd0);

    // Single request, done on the third grant cycle, then re-grant.
    rst_n = 1'b1; req = 8'h20;
    tick(); chk_out("single_c1", 1'b1, 3'd5, 1'b0);
    tick(); chk_out("single_c2", 1'b1, 3'd5, 1'b0);
    tick(); chk_out("single_c3", 1'b1, 3'd5, 1'b0);
    done = 1'b1;
    tick(); chk_out("single_rel", 1'b0, 3'd5, 1'b0);
    chk("single_ptr", {5'd0, dbg_ptr}, 8'd6);
    done = 1'b0;
    tick(); chk_out("single_regrant", 1'b1, 3'd5, 1'b0);
    req = 8'h00;
    tick(); chk_out("single_drop", 1'b0, 3'd5, 1'b0);

    // Reset back to ptr=0, then full fairness sweep.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick(); chk_out($sformatf("rr_g%0d", i), 1'b1, 3'(i % 8), 1'b0);
      done = 1'b1;
      tick(); chk_out($sformatf("rr_dead%0d", i), 1'b0, 3'(i % 8), 1'b0);
      done = 1'b0;
    end
    chk("rr_ptr", {5'd0, dbg_ptr}, 8'd1);

    // Pointer wrap from channel 7 to 0.
    req = 8'h81;
    tick(); chk_out("wrap_g7", 1'b1, 3'd7, 1'b0);
    done = 1'b1;
    tick(); chk_out("wrap_rel", 1'b0, 3'd7, 1'b0);
    chk("wrap_ptr", {5'd0, dbg_ptr}, 8'd0);
    done = 1'b0;
    tick(); chk_out("wrap_g0", 1'b1, 3'd0, 1'b0);
    done = 1'b1; req = 8'h00;
    tick(); chk_out("wrap_rel0", 1'b0, 3'd0, 1'b0);
    done = 1'b0;

    // Hold limit: four grant cycles, timeout pulse, re-grant.
    req = 8'h04;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_out($sformatf("hold_c%0d", i + 1), 1'b1, 3'd2, 1'b0);
    end
    tick(); chk_out("hold_to", 1'b0, 3'd2, 1'b1);
    chk("hold_ptr", {5'd0, dbg_ptr}, 8'd3);
    tick(); chk_out("hold_regrant", 1'b1, 3'd2, 1'b0);

    // done coincident with the hold limit wins, no timeout.
    tick(); tick(); tick();
    chk_out("simul_c4", 1'b1, 3'd2, 1'b0);
    done = 1'b1;
    tick(); chk_out("simul_rel", 1'b0, 3'd2, 1'b0);
    done = 1'b0;

    // Request drop in the second grant cycle.
    req = 8'h08;
    tick(); chk_out("drop_c1", 1'b1, 3'd3, 1'b0);
    tick(); chk_out("drop_c2", 1'b1, 3'd3, 1'b0);
    req = 8'h00;
    tick(); chk_out("drop_rel", 1'b0, 3'd3, 1'b0);
    chk("drop_idx_hold", {5'd0, g2, g1, g0}, 8'd3);
    chk("drop_ptr", {5'd0, dbg_ptr}, 8'd4);

    // Reset mid-grant, with done coincident.
    req = 8'h02;
    tick(); chk_out("rst_c1", 1'b1, 3'd1, 1'b0);
    tick(); chk_out("rst_c2", 1'b1, 3'd1, 1'b0);
    rst_n = 1'b0; done = 1'b1;
    tick(); chk_out("rst_mid", 1'b0, 3'd0, 1'b0);
    chk("rst_mid_idx", {5'd0, g2, g1, g0}, 8'd0);
    chk("rst_mid_ptr", {5'd0, dbg_ptr}, 8'd0);
    rst_n = 1'b1; req = 8'h00;
    tick(); chk_out("rst_after", 1'b0, 3'd0, 1'b0);
    chk("idle_done_ptr", {5'd0, dbg_ptr}, 8'd0);
    done = 1'b0;
    tick(); chk_out("idle_stay", 1'b0, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
